// File: rtl/lsu_mem_port_if.sv
// Signal bundle for lsu_mem_port: AGU beat input, data-memory port and LSU result bus.
// master = surrounding pipeline/memory side, slave = the LSU port itself.
interface lsu_mem_port_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 5
);
    logic              flush;
    logic              freeze_back;
    logic              valid_Addr_agu;
    logic [ADDR_W-1:0] Addr_agu;
    logic [TAG_W-1:0]  tag_ROB_Result_agu;
    logic              is_store_agu;
    logic [DATA_W-1:0] data_store_agu;
    logic              full_lsu;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              valid_Result_lsu;
    logic [DATA_W-1:0] Result_lsu;
    logic [TAG_W-1:0]  tag_ROB_Result_lsu;

    modport master (
        output flush, freeze_back, valid_Addr_agu, Addr_agu, tag_ROB_Result_agu,
               is_store_agu, data_store_agu, mem_ready, mem_rvalid, mem_rdata,
        input  full_lsu, mem_req, mem_we, mem_addr, mem_wdata,
               valid_Result_lsu, Result_lsu, tag_ROB_Result_lsu
    );

    modport slave (
        input  flush, freeze_back, valid_Addr_agu, Addr_agu, tag_ROB_Result_agu,
               is_store_agu, data_store_agu, mem_ready, mem_rvalid, mem_rdata,
        output full_lsu, mem_req, mem_we, mem_addr, mem_wdata,
               valid_Result_lsu, Result_lsu, tag_ROB_Result_lsu
    );
endinterface

// File: rtl/lsu_mem_port.sv
// LSU memory port: buffers AGU beats in an in-order FIFO, issues them one at a time
// to data memory and broadcasts each completion with its ROB tag.
module lsu_mem_port #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 5
) (
    input logic           clk,
    input logic           rst,
    lsu_mem_port_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              is_store;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, DRAIN} state_t;

    entry_t            fifo_q [DEPTH];
    entry_t            head;
    entry_t            beat_in;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    state_t            state_q, state_d;
    logic              push, pop, res_load;
    logic [DATA_W-1:0] res_data_d, res_data_q;
    logic [TAG_W-1:0]  res_tag_q;

    assign head    = fifo_q[rd_ptr_q];
    assign beat_in = '{is_store: bus.is_store_agu, tag: bus.tag_ROB_Result_agu,
                       addr: bus.Addr_agu, data: bus.data_store_agu};

    assign bus.full_lsu           = (count_q == CNT_W'(DEPTH));
    assign push                   = bus.valid_Addr_agu && !bus.full_lsu && !bus.flush;
    assign bus.valid_Result_lsu   = (state_q == WB);
    assign bus.Result_lsu         = res_data_q;
    assign bus.tag_ROB_Result_lsu = res_tag_q;

    // Next-state, memory request and result-capture decode
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        res_load      = 1'b0;
        res_data_d    = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            IDLE: if (count_q != '0) state_d = REQ;
            REQ: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = head.is_store;
                bus.mem_addr  = head.addr;
                bus.mem_wdata = head.data;
                if (bus.mem_ready) begin
                    if (head.is_store) begin
                        res_load = 1'b1;
                        state_d  = WB;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: if (bus.mem_rvalid) begin
                res_load   = 1'b1;
                res_data_d = bus.mem_rdata;
                state_d    = WB;
            end
            WB: if (!bus.freeze_back) begin
                pop     = 1'b1;
                state_d = IDLE;
            end
            DRAIN: if (bus.mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A load already accepted by memory must have its response swallowed in DRAIN
        if (bus.flush) begin
            pop      = 1'b0;
            res_load = 1'b0;
            case (state_q)
                REQ:         state_d = (bus.mem_ready && !head.is_store) ? DRAIN : IDLE;
                WAIT, DRAIN: state_d = bus.mem_rvalid ? IDLE : DRAIN;
                default:     state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            res_data_q <= '0;
            res_tag_q  <= '0;
        end else begin
            state_q <= state_d;
            if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            end
            if (res_load) begin
                res_data_q <= res_data_d;
                res_tag_q  <= head.tag;
            end
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (!rst && push) fifo_q[wr_ptr_q] <= beat_in;
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed latency/full/freeze/flush/reset scenarios followed by
// randomized traffic scored against a transaction-level queue model.
module tb_lsu_mem_port;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAG_W  = 5;

    typedef struct {
        logic              st;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } beat_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lsu_mem_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    lsu_mem_port #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic              rv_nx;
    logic [DATA_W-1:0] rv_dn;
    res_t              got[$];
    beat_t             mq[$];
    res_t              eq[$];
    int                rv_wait = 0;
    logic [DATA_W-1:0] rv_data;
    logic              have_beat = 1'b0;
    beat_t             beat;
    int                n_done = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rd_of(input logic [ADDR_W-1:0] a);
        case (a)
            16'h0040: return 16'hBEEF;
            16'h00A0: return 16'hAAAA;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait memory: a load accepted this cycle returns rd_of(addr) next cycle
    task automatic mem_tick();
        rv_nx = bus.mem_req && bus.mem_ready && !bus.mem_we;
        rv_dn = rd_of(bus.mem_addr);
        tick();
        bus.mem_rvalid = rv_nx;
        bus.mem_rdata  = rv_nx ? rv_dn : '0;
    endtask

    task automatic drive_beat(input logic v, input logic st, input logic [TAG_W-1:0] t,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.valid_Addr_agu     = v;
        bus.is_store_agu       = st;
        bus.tag_ROB_Result_agu = t;
        bus.Addr_agu           = a;
        bus.data_store_agu     = d;
    endtask

    task automatic single_load(input string name, input logic [ADDR_W-1:0] a,
                               input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] exp_d);
        bus.mem_ready   = 1'b1;
        bus.freeze_back = 1'b0;
        bus.flush       = 1'b0;
        drive_beat(1'b1, 1'b0, t, a, '0);
        mem_tick();
        drive_beat(1'b0, 1'b0, '0, '0, '0);
        chk({name, "_n1_req"}, 32'(bus.mem_req), 32'd0);
        mem_tick();
        chk({name, "_n2_req"}, 32'(bus.mem_req), 32'd1);
        chk({name, "_n2_addr"}, 32'(bus.mem_addr), 32'(a));
        chk({name, "_n2_we"}, 32'(bus.mem_we), 32'd0);
        mem_tick();
        chk({name, "_n3_valid"}, 32'(bus.valid_Result_lsu), 32'd0);
        mem_tick();
        chk({name, "_n4_valid"}, 32'(bus.valid_Result_lsu), 32'd1);
        chk({name, "_n4_data"}, 32'(bus.Result_lsu), 32'(exp_d));
        chk({name, "_n4_tag"}, 32'(bus.tag_ROB_Result_lsu), 32'(t));
        mem_tick();
        chk({name, "_n5_valid"}, 32'(bus.valid_Result_lsu), 32'd0);
    endtask

    // One cycle of randomized traffic; mq/eq hold queued beats and pending completions
    task automatic rnd_cycle(input int unsigned p_flush, input int unsigned p_freeze,
                             input int unsigned p_ready, input int unsigned p_beat);
        logic push_ok;
        bus.flush       = ($urandom_range(0, 99) < p_flush);
        bus.freeze_back = ($urandom_range(0, 99) < p_freeze);
        bus.mem_ready   = ($urandom_range(0, 99) < p_ready);
        bus.mem_rvalid  = (rv_wait == 1);
        bus.mem_rdata   = (rv_wait == 1) ? rv_data : DATA_W'($urandom);
        if (!have_beat && ($urandom_range(0, 99) < p_beat)) begin
            beat.st   = 1'($urandom_range(0, 1));
            beat.tag  = TAG_W'($urandom);
            beat.addr = ADDR_W'($urandom);
            beat.data = DATA_W'($urandom);
            have_beat = 1'b1;
        end
        drive_beat(have_beat, beat.st, beat.tag, beat.addr, beat.data);

        chk("rnd_full", 32'(bus.full_lsu), 32'(mq.size() == DEPTH));
        if (!bus.mem_req)
            chk("rnd_mem_idle", 32'({bus.mem_addr, bus.mem_wdata}) | 32'(bus.mem_we), 32'd0);
        push_ok = have_beat && (mq.size() < DEPTH) && !bus.flush;

        if (bus.mem_req && bus.mem_ready) begin
            chk("rnd_req_pending", 32'(mq.size() != 0), 32'd1);
            if (mq.size() != 0) begin
                chk("rnd_req_we", 32'(bus.mem_we), 32'(mq[0].st));
                chk("rnd_req_addr", 32'(bus.mem_addr), 32'(mq[0].addr));
                if (mq[0].st) begin
                    chk("rnd_req_wdata", 32'(bus.mem_wdata), 32'(mq[0].data));
                    eq.push_back('{'0, mq[0].tag});
                end else begin
                    rv_data = DATA_W'($urandom);
                    rv_wait = $urandom_range(1, 3);
                    eq.push_back('{rv_data, mq[0].tag});
                end
            end
        end else if (rv_wait > 0) begin
            rv_wait--;
        end

        if (bus.valid_Result_lsu) begin
            chk("rnd_res_pending", 32'(eq.size()), 32'd1);
            if (eq.size() != 0) begin
                chk("rnd_res_data", 32'(bus.Result_lsu), 32'(eq[0].data));
                chk("rnd_res_tag", 32'(bus.tag_ROB_Result_lsu), 32'(eq[0].tag));
                if (!bus.freeze_back && !bus.flush) begin
                    void'(eq.pop_front());
                    if (mq.size() != 0) void'(mq.pop_front());
                    n_done++;
                end
            end
        end

        if (push_ok) begin
            mq.push_back(beat);
            have_beat = 1'b0;
        end
        if (bus.flush) begin
            mq.delete();
            eq.delete();
        end
        tick();
    endtask

    initial begin
        rst             = 1'b1;
        bus.flush       = 1'b0;
        bus.freeze_back = 1'b0;
        bus.mem_ready   = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;
        drive_beat(1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_full", 32'(bus.full_lsu), 32'd0);
        chk("rst_valid", 32'(bus.valid_Result_lsu), 32'd0);
        chk("rst_result", 32'(bus.Result_lsu), 32'd0);
        chk("rst_tag", 32'(bus.tag_ROB_Result_lsu), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);

        // Single load, zero-wait memory
        single_load("ld", 16'h0040, 5'd3, 16'hBEEF);

        // Store ack
        drive_beat(1'b1, 1'b1, 5'd7, 16'h0010, 16'h1234);
        mem_tick();
        drive_beat(1'b0, 1'b0, '0, '0, '0);
        chk("st_n1_req", 32'(bus.mem_req), 32'd0);
        mem_tick();
        chk("st_n2_req", 32'(bus.mem_req), 32'd1);
        chk("st_n2_we", 32'(bus.mem_we), 32'd1);
        chk("st_n2_addr", 32'(bus.mem_addr), 32'h0010);
        chk("st_n2_wdata", 32'(bus.mem_wdata), 32'h1234);
        mem_tick();
        chk("st_n3_valid", 32'(bus.valid_Result_lsu), 32'd1);
        chk("st_n3_data", 32'(bus.Result_lsu), 32'd0);
        chk("st_n3_tag", 32'(bus.tag_ROB_Result_lsu), 32'd7);
        mem_tick();
        chk("st_n4_valid", 32'(bus.valid_Result_lsu), 32'd0);

        // Full / back-pressure with memory stalled
        bus.mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_beat(1'b1, 1'b0, TAG_W'(i), 16'h0100 + 16'(i), '0);
            chk("full_before_push", 32'(bus.full_lsu), 32'd0);
            mem_tick();
        end
        drive_beat(1'b1, 1'b0, 5'd5, 16'h0105, '0);
        for (int i = 0; i < 3; i++) begin
            chk("full_held", 32'(bus.full_lsu), 32'd1);
            mem_tick();
        end
        bus.mem_ready = 1'b1;
        got.delete();
        begin : full_drain
            logic take5;
            take5 = 1'b0;
            for (int cyc = 0; cyc < 80 && got.size() < 5; cyc++) begin
                if (bus.valid_Addr_agu && !bus.full_lsu) begin
                    chk("full_tag5_after_pop", 32'(got.size()), 32'd1);
                    take5 = 1'b1;
                end
                if (bus.valid_Result_lsu)
                    got.push_back('{bus.Result_lsu, bus.tag_ROB_Result_lsu});
                mem_tick();
                if (take5) drive_beat(1'b0, 1'b0, '0, '0, '0);
            end
        end
        chk("full_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < got.size(); i++) begin
            chk("full_order_tag", 32'(got[i].tag), 32'(i + 1));
            chk("full_order_data", 32'(got[i].data), 32'(rd_of(16'h0100 + 16'(i + 1))));
        end
        mem_tick();

        // Writeback freeze holds the result and delays the pop
        drive_beat(1'b1, 1'b0, 5'd2, 16'h00A0, '0);
        mem_tick();
        drive_beat(1'b1, 1'b0, 5'd4, 16'h0B00, '0);
        mem_tick();
        drive_beat(1'b0, 1'b0, '0, '0, '0);
        for (int cyc = 0; cyc < 20 && !bus.valid_Result_lsu; cyc++) mem_tick();
        for (int i = 0; i < 4; i++) begin
            chk("frz_valid", 32'(bus.valid_Result_lsu), 32'd1);
            chk("frz_data", 32'(bus.Result_lsu), 32'hAAAA);
            chk("frz_tag", 32'(bus.tag_ROB_Result_lsu), 32'd2);
            bus.freeze_back = (i < 3);
            mem_tick();
        end
        bus.freeze_back = 1'b0;
        chk("frz_popped", 32'(bus.valid_Result_lsu), 32'd0);
        for (int cyc = 0; cyc < 20 && !bus.valid_Result_lsu; cyc++) mem_tick();
        chk("frz_next_valid", 32'(bus.valid_Result_lsu), 32'd1);
        chk("frz_next_tag", 32'(bus.tag_ROB_Result_lsu), 32'd4);
        chk("frz_next_data", 32'(bus.Result_lsu), 32'(rd_of(16'h0B00)));
        mem_tick();

        // Flush with a load outstanding and a second entry queued
        bus.mem_ready = 1'b1;
        drive_beat(1'b1, 1'b0, 5'd8, 16'h0200, '0);
        tick();
        drive_beat(1'b1, 1'b0, 5'd9, 16'h0210, '0);
        tick();
        drive_beat(1'b0, 1'b0, '0, '0, '0);
        chk("fl_req", 32'(bus.mem_req), 32'd1);
        chk("fl_req_addr", 32'(bus.mem_addr), 32'h0200);
        tick();
        chk("fl_wait_req", 32'(bus.mem_req), 32'd0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl_drain_valid", 32'(bus.valid_Result_lsu), 32'd0);
        chk("fl_drain_full", 32'(bus.full_lsu), 32'd0);
        chk("fl_drain_req", 32'(bus.mem_req), 32'd0);
        drive_beat(1'b1, 1'b0, 5'd10, 16'h0300, '0);
        tick();
        drive_beat(1'b0, 1'b0, '0, '0, '0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'h5555;
        chk("fl_rv_valid", 32'(bus.valid_Result_lsu), 32'd0);
        chk("fl_rv_req", 32'(bus.mem_req), 32'd0);
        tick();
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        chk("fl_idle_valid", 32'(bus.valid_Result_lsu), 32'd0);
        chk("fl_idle_req", 32'(bus.mem_req), 32'd0);
        tick();
        chk("fl_new_req", 32'(bus.mem_req), 32'd1);
        chk("fl_new_addr", 32'(bus.mem_addr), 32'h0300);
        chk("fl_new_nores", 32'(bus.valid_Result_lsu), 32'd0);
        mem_tick();
        chk("fl_new_wait", 32'(bus.valid_Result_lsu), 32'd0);
        mem_tick();
        chk("fl_new_valid", 32'(bus.valid_Result_lsu), 32'd1);
        chk("fl_new_data", 32'(bus.Result_lsu), 32'(rd_of(16'h0300)));
        chk("fl_new_tag", 32'(bus.tag_ROB_Result_lsu), 32'd10);
        mem_tick();
        chk("fl_new_done", 32'(bus.valid_Result_lsu), 32'd0);

        // Reset in the middle of a stalled request with three entries queued
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_beat(1'b1, 1'b0, TAG_W'(11 + i), 16'h0400 + 16'(i), '0);
            tick();
        end
        drive_beat(1'b0, 1'b0, '0, '0, '0);
        chk("rs_req_before", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_req", 32'(bus.mem_req), 32'd0);
        chk("rs_full", 32'(bus.full_lsu), 32'd0);
        chk("rs_valid", 32'(bus.valid_Result_lsu), 32'd0);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_empty", 32'(bus.mem_req), 32'd0);
        end
        single_load("rs_ld", 16'h0500, 5'd21, rd_of(16'h0500));

        // Randomized traffic against the queue model, then drain
        for (int i = 0; i < 2000; i++) rnd_cycle(3, 30, 60, 50);
        for (int i = 0; i < 400 && (have_beat || mq.size() != 0 || rv_wait != 0); i++)
            rnd_cycle(0, 0, 100, 0);
        chk("rnd_drained", 32'(mq.size()), 32'd0);
        chk("rnd_progress", 32'(n_done > 20), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Consumer end of the AGU address interface.
- Accepts registered {valid, address, ROB tag} beats from the AGU and buffers them in an in-order FIFO.
- Issues each entry to the data memory over a req/ready + rvalid handshake.
- Broadcasts the completion (load data or store ack) with its ROB tag on the LSU result bus.
- Sits between the AGU and the CDB/ROB writeback arbiter, and drives back-pressure to the AGU.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TAG_W, 5, ROB tag width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  pipeline flush (branch mispredict/exception)
- freeze_back  in  1  writeback stall; result outputs must hold
- valid_Addr_agu  in  1  AGU beat valid
- Addr_agu  in  ADDR_W  effective address
- tag_ROB_Result_agu  in  TAG_W  ROB tag of the beat
- is_store_agu  in  1  1=store, 0=load
- data_store_agu  in  DATA_W  store data, aligned with the beat
- full_lsu  out  1  FIFO full; upstream holds its beat (freeze) while high
- mem_req  out  1  memory request valid
- mem_we  out  1  1=write
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  request accepted this cycle (meaningful only with mem_req)
- mem_rvalid  in  1  load data valid, ≥1 cycle after acceptance, at most one outstanding
- mem_rdata  in  DATA_W  load data
- valid_Result_lsu  out  1  result valid
- Result_lsu  out  DATA_W  load data; 0 for stores
- tag_ROB_Result_lsu  out  TAG_W  ROB tag of the result

Behaviour:
- Reset: all registered outputs, FIFO pointers and count = 0; state = IDLE. rst overrides flush and every other input.
- FIFO push:
  - Push occurs when valid_Addr_agu && !full_lsu.
  - full_lsu = (count == DEPTH), combinational from count.
  - A beat presented while full is ignored; upstream must hold it.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- FSM states: IDLE, REQ, WAIT, WB, DRAIN.
  - IDLE: if count != 0, go to REQ.
  - REQ: mem_req = 1; mem_we/mem_addr/mem_wdata come from the FIFO head.
    - On mem_ready with a load: go to WAIT.
    - On mem_ready with a store: load result regs {Result = 0, tag = head tag} and go to WB.
    - Otherwise stay in REQ with stable request fields.
  - WAIT: on mem_rvalid, load result regs {mem_rdata, head tag} and go to WB.
  - WB: valid_Result_lsu = 1.
    - If !freeze_back: pop the head and go to IDLE.
    - If freeze_back: hold state and all result outputs.
  - DRAIN: mem_req = 0. On mem_rvalid, discard the data and go to IDLE. Pushes are accepted during DRAIN.
- mem_req is asserted only in REQ. Memory outputs are 0 outside REQ.
- valid_Result_lsu is high only in WB. Result/tag are don't-care outside WB but are not required to clear.
- Latency with a zero-wait memory:
  - Beat in cycle N (FIFO empty, IDLE).
  - REQ in N+2, accepted in N+2.
  - rvalid in N+3.
  - valid_Result_lsu in N+4 for loads.
  - Store ack in N+3.
- Flush (priority over everything except rst):
  - Empty the FIFO (pointers and count = 0) and force valid_Result_lsu = 0 next cycle; this applies in WB even under freeze_back.
  - A push in the same cycle is dropped.
  - State after flush:
    - from WAIT: DRAIN
    - from REQ with mem_ready and a load: DRAIN
    - from REQ with mem_ready and a store: IDLE (the store is performed, with no ack)
    - from DRAIN: stays DRAIN
    - all other states: IDLE
- Flush together with mem_rvalid in WAIT/DRAIN: data discarded, go to IDLE.
- mem_rvalid in IDLE/REQ/WB is a protocol violation and is ignored.

Test Plan:
- Single load: reset, then beat {0x0040, tag 3, load} at N; mem always ready, rvalid at N+3 with 0xBEEF -> mem_req/addr 0x0040 at N+2; valid_Result_lsu=1, Result_lsu=0xBEEF, tag 3 at N+4 for exactly 1 cycle.
- Store ack: beat {0x0010, tag 7, store, data 0x1234} -> mem_req=1, mem_we=1, wdata 0x1234 at N+2; valid_Result_lsu=1, Result_lsu=0, tag 7 at N+3.
- Full/back-pressure: hold mem_ready=0, push 5 loads on consecutive cycles (tags 1..5) -> full_lsu rises after the 4th push; tag 5 is not taken until a pop; results emerge in order 1..5 once ready=1.
- freeze_back: in WB with tag 2 / 0xAAAA, hold freeze_back 3 cycles -> outputs stable for 4 cycles; pop occurs only on the cycle freeze_back=0; the next entry is unaffected.
- Flush with outstanding load: flush in WAIT with 2 entries queued; rvalid 0x5555 two cycles later -> count=0, no valid_Result_lsu for 0x5555, state returns to IDLE; a fresh load afterwards completes normally.
- Reset mid-operation: rst=1 during REQ with 3 entries queued -> next cycle mem_req=0, full_lsu=0, valid_Result_lsu=0, FIFO empty; a subsequent single load completes at N+4.
